// File: rtl/serial_pkg.sv
// ---------------------------------------------------------------------------
// serial_pkg
// Shared definitions for the serial transmit path (and the future receive
// path): parity mode encodings, transmitter FSM state encoding, a baud-rate
// helper constant and the parity helper used when a word is loaded.
// ---------------------------------------------------------------------------
package serial_pkg;

    // Parity mode encodings for the PARITY parameter
    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // 50 MHz / 434 is roughly 115200 baud
    localparam int CLK_PER_BIT_115200_50M = 434;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } tx_state_e;

    // The word arrives zero-extended to 9 bits, so the unused upper bits
    // never disturb the XOR reduction.
    function automatic logic calc_parity(input logic [8:0] word, input int mode);
        calc_parity = (mode == PAR_ODD) ? ~(^word) : (^word);
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// ---------------------------------------------------------------------------
// fifo_sync
// Single-clock first-word-fall-through FIFO. The head word is always present
// on dout while empty=0; rd acknowledges it.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (empties the FIFO)
//   wr, din       write strobe and data; ignored while full
//   rd            pop the head word; ignored while empty
//   dout          head word (valid while empty=0)
//   full, empty   registered status flags
//   level         registered number of stored words
//
// Handshake: a write is accepted on any edge where wr=1 and full=1 is not
// shown; a pop happens on any edge where rd=1 and empty=0. Both flags are
// the values before the edge, so a pop never makes room for a write on the
// same edge.
// ---------------------------------------------------------------------------
module fifo_sync #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr,
    input  logic [WIDTH-1:0]       din,
    input  logic                   rd,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             push, pop;

    always_comb begin
        push     = wr && !full_q;
        pop      = rd && !empty_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        full_d  = (count_d == FULL_CNT);
        empty_d = (count_d == '0);
    end

    // Storage needs no reset; the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;
    assign level = count_q;

endmodule

// File: rtl/serial_tx_buf.sv
// ---------------------------------------------------------------------------
// serial_tx_buf
// Buffered UART-style transmitter. Words written with new_data are queued in
// a FIFO and sent LSB-first as: start bit, DATA_BITS data bits, optional
// parity bit, STOP_BITS stop bits, each CLK_PER_BIT clocks long. Queued
// frames follow one another with no idle gap.
//
// Ports:
//   clk, rst    clock, synchronous active-high reset (aborts any frame)
//   block       holds off frame starts; a frame already started completes
//   new_data    write strobe for data; dropped (overflow) while full=1
//   data        word to transmit
//   full        FIFO holds FIFO_DEPTH words
//   overflow    one-cycle pulse after a strobe that was dropped
//   level       words queued, not counting the frame on the wire
//   busy        a frame is in progress or words are queued
//   tx          serial line, idles high, driven straight from a flop
//   state_dbg   current FSM state
//
// Handshake: new_data is a strobe with no back-pressure; the word is taken
// on the edge where new_data=1 and full=0, otherwise it is lost and
// overflow rises for the following cycle.
// ---------------------------------------------------------------------------
module serial_tx_buf
    import serial_pkg::*;
#(
    parameter int CLK_PER_BIT = CLK_PER_BIT_115200_50M,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = PAR_NONE,
    parameter int STOP_BITS   = 1,
    parameter int FIFO_DEPTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        block,
    input  logic                        new_data,
    input  logic [DATA_BITS-1:0]        data,
    output logic                        full,
    output logic                        overflow,
    output logic [$clog2(FIFO_DEPTH):0] level,
    output logic                        busy,
    output logic                        tx,
    output tx_state_e                   state_dbg
);

    localparam int TW = $clog2(CLK_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLK_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST   = BW'(DATA_BITS - 1);
    // stop_cnt_q indexes the stop bit being sent; this is the final one
    localparam logic          STOP_LAST  = (STOP_BITS == 2);

    logic                 fifo_rd;
    logic                 fifo_empty;
    logic [DATA_BITS-1:0] fifo_dout;

    tx_state_e            state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d;
    logic                 tx_q, tx_d;
    logic                 overflow_q;

    logic                 start_ok;
    logic                 bit_end;
    logic                 do_pop;

    fifo_sync #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (new_data),
        .din   (data),
        .rd    (fifo_rd),
        .dout  (fifo_dout),
        .full  (full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        do_pop     = 1'b0;
        tx_d       = 1'b1;

        start_ok = !fifo_empty && !block;
        bit_end  = (timer_q == TIMER_LAST);

        // The bit timer free-runs while a frame is on the wire and wraps at
        // every bit boundary.
        if (state_q != ST_IDLE) begin
            timer_d = bit_end ? '0 : timer_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                timer_d = '0;
                if (start_ok) begin
                    do_pop  = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_DATA;
                    bit_cnt_d = '0;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    if (bit_cnt_q == BIT_LAST) begin
                        state_d    = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                        stop_cnt_d = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_cnt_d = 1'b0;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_cnt_q == STOP_LAST) begin
                        // Chain straight into the next start bit when possible
                        if (start_ok) begin
                            do_pop  = 1'b1;
                            state_d = ST_START;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Parity is fixed when the word is loaded, before it is shifted out.
        fifo_rd = do_pop;
        if (do_pop) begin
            shift_d = fifo_dout;
            par_d   = calc_parity(9'(fifo_dout), PARITY);
        end

        // tx is decoded from the next state so the line flop changes on the
        // same edge as the state it belongs to.
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = par_d;
            default:   tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            timer_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            overflow_q <= new_data && full;
        end
    end

    assign tx        = tx_q;
    assign overflow  = overflow_q;
    assign busy      = (state_q != ST_IDLE) || !fifo_empty;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_tx_buf.sv
// ---------------------------------------------------------------------------
// tb_serial_tx_buf
// Three transmitters at CLK_PER_BIT=4: u_a (8N1, FIFO depth 4) fed by nd_a,
// u_e (8E2) and u_o (8O2) fed together by nd_eo. A receiver model decodes
// u_a's line cycle by cycle and pops the expected-word queue per frame.
// ---------------------------------------------------------------------------
module tb_serial_tx_buf;
  import serial_pkg::*;

  localparam int CPB     = 4;
  localparam int FRAME_A = 10 * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic block = 1'b0;
  logic nd_a = 1'b0;
  logic nd_eo = 1'b0;
  logic [7:0] din = 8'h00;

  logic a_full, a_ovf, a_busy, a_tx;
  logic [2:0] a_level;
  tx_state_e a_st;
  logic e_full, e_ovf, e_busy, e_tx;
  logic [4:0] e_level;
  tx_state_e e_st;
  logic o_full, o_ovf, o_busy, o_tx;
  logic [4:0] o_level;
  tx_state_e o_st;

  int cmp_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int rx_starts[$];
  bit rx_en = 1'b1;
  int rx_ph = -1;
  int rx_bi, rx_wi;
  logic [7:0] rx_word;
  logic rx_bit;

  serial_tx_buf #(.CLK_PER_BIT(CPB), .FIFO_DEPTH(4)) u_a (
    .clk(clk), .rst(rst), .block(block), .new_data(nd_a), .data(din),
    .full(a_full), .overflow(a_ovf), .level(a_level), .busy(a_busy),
    .tx(a_tx), .state_dbg(a_st)
  );

  serial_tx_buf #(.CLK_PER_BIT(CPB), .PARITY(PAR_EVEN), .STOP_BITS(2)) u_e (
    .clk(clk), .rst(rst), .block(block), .new_data(nd_eo), .data(din),
    .full(e_full), .overflow(e_ovf), .level(e_level), .busy(e_busy),
    .tx(e_tx), .state_dbg(e_st)
  );

  serial_tx_buf #(.CLK_PER_BIT(CPB), .PARITY(PAR_ODD), .STOP_BITS(2)) u_o (
    .clk(clk), .rst(rst), .block(block), .new_data(nd_eo), .data(din),
    .full(o_full), .overflow(o_ovf), .level(o_level), .busy(o_busy),
    .tx(o_tx), .state_dbg(o_st)
  );

  // clock / cycle count
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [7:0] w, input bit accept);
    nd_a = 1'b1;
    din = w;
    if (accept) exp_q.push_back(w);
    tick();
    nd_a = 1'b0;
  endtask

  // wire order, index 0 first: start, d0..d7, parity, stop, stop
  function automatic logic [11:0] frame_bits(input logic [7:0] w, input logic par);
    frame_bits = {2'b11, par, w, 1'b0};
  endfunction

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rx_ph >= 0) && n < 600) begin
      tick();
      n++;
    end
    check({tag, "_drain_left"}, exp_q.size(), 0);
    tick();
    check({tag, "_idle_busy"}, a_busy, 1'b0);
    check({tag, "_idle_tx"}, a_tx, 1'b1);
  endtask

  // receiver model for u_a: 8N1, every cycle of every bit is checked
  initial forever begin
    @(posedge clk);
    #1;
    if (!rx_en) begin
      rx_ph = -1;
    end else begin
      if (rx_ph < 0 && a_tx === 1'b0) begin
        rx_ph = 0;
        rx_starts.push_back(cyc);
      end
      if (rx_ph >= 0) begin
        rx_bi = rx_ph / CPB;
        rx_wi = rx_ph % CPB;
        if (rx_wi == 0) begin
          rx_bit = a_tx;
          if (rx_bi == 9) check("rx_stop", a_tx, 1'b1);
          else if (rx_bi > 0) rx_word[rx_bi-1] = a_tx;
        end else begin
          check("rx_bit_hold", a_tx, rx_bit);
        end
        if (rx_ph == FRAME_A - 1) begin
          cmp_cnt++;
          assert (exp_q.size() != 0) else begin
            err_cnt++;
            $error("FAIL rx_extra_frame: observed %0h expected none", rx_word);
          end
          if (exp_q.size() != 0) check("rx_word", rx_word, exp_q.pop_front());
          rx_ph = -1;
        end else begin
          rx_ph++;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [11:0] ef[2];
    logic [11:0] of[2];
    logic [7:0] pw[2];
    int idx;

    // reset
    tick();
    tick();
    check("rst_tx", a_tx, 1'b1);
    check("rst_busy", a_busy, 1'b0);
    check("rst_full", a_full, 1'b0);
    check("rst_ovf", a_ovf, 1'b0);
    check("rst_level", a_level, 0);
    check("rst_e_tx", e_tx, 1'b1);
    check("rst_o_busy", o_busy, 1'b0);
    rst = 1'b0;
    tick();
    check("post_rst_state", a_st, ST_IDLE);

    // single 0x61 frame: latency, content, busy, length
    rx_starts.delete();
    write_a(8'h61, 1'b1);
    check("t1_level_after_write", a_level, 1);
    check("t1_busy_after_write", a_busy, 1'b1);
    check("t1_tx_before_start", a_tx, 1'b1);
    tick();
    check("t1_tx_start", a_tx, 1'b0);
    check("t1_level_after_pop", a_level, 0);
    repeat (39) tick();
    check("t1_busy_last_stop", a_busy, 1'b1);
    check("t1_tx_last_stop", a_tx, 1'b1);
    tick();
    check("t1_busy_done", a_busy, 1'b0);
    check("t1_exp_consumed", exp_q.size(), 0);
    check("t1_frame_count", rx_starts.size(), 1);

    // parity frames on u_e / u_o: 0x07 then 0xB1 back-to-back
    pw[0] = 8'h07;
    pw[1] = 8'hB1;
    ef[0] = frame_bits(pw[0], 1'b1);
    of[0] = frame_bits(pw[0], 1'b0);
    ef[1] = frame_bits(pw[1], ($countones(pw[1]) % 2) == 1);
    of[1] = frame_bits(pw[1], ($countones(pw[1]) % 2) == 0);
    for (int i = 0; i < 2; i++) begin
      nd_eo = 1'b1;
      din = pw[i];
      tick();
    end
    nd_eo = 1'b0;
    // first start bit began on the edge after the first write
    for (int c = 0; c < 96; c++) begin
      idx = (c % 48) / CPB;
      check("par_even_tx", e_tx, ef[c / 48][idx]);
      check("par_odd_tx", o_tx, of[c / 48][idx]);
      if (c < 95) tick();
    end
    check("par_busy_last", e_busy, 1'b1);
    tick();
    check("par_even_done", e_busy, 1'b0);
    check("par_odd_done", o_busy, 1'b0);
    check("par_even_idle_tx", e_tx, 1'b1);

    // overflow: depth 4 filled under block, 5th dropped, then drop on pop edge
    block = 1'b1;
    for (int i = 0; i < 5; i++) begin
      write_a(8'h11 + 8'(i), i < 4);
      check("ovf_pulse", a_ovf, i == 4);
      check("ovf_full", a_full, i >= 3);
    end
    tick();
    check("ovf_pulse_end", a_ovf, 1'b0);
    check("ovf_level", a_level, 4);
    check("ovf_tx_idle", a_tx, 1'b1);
    rx_starts.delete();
    block = 1'b0;
    write_a(8'h16, 1'b0);
    check("ovf_pop_edge_drop", a_ovf, 1'b1);
    check("ovf_pop_level", a_level, 3);
    check("ovf_pop_tx", a_tx, 1'b0);
    check("ovf_pop_full", a_full, 1'b0);
    drain("ovf");
    check("ovf_frames", rx_starts.size(), 4);
    for (int i = 0; i < 3; i++) begin
      if (rx_starts.size() > i + 1)
        check("ovf_b2b_gap", rx_starts[i+1] - rx_starts[i], FRAME_A);
    end

    // block: held words, then block raised during frame 1
    block = 1'b1;
    write_a(8'h3C, 1'b1);
    write_a(8'hC3, 1'b1);
    write_a(8'h5A, 1'b1);
    check("blk_level", a_level, 3);
    check("blk_busy", a_busy, 1'b1);
    repeat (10) tick();
    check("blk_tx_held", a_tx, 1'b1);
    check("blk_level_held", a_level, 3);
    check("blk_state", a_st, ST_IDLE);
    rx_starts.delete();
    block = 1'b0;
    tick();
    check("blk_f1_start", a_tx, 1'b0);
    check("blk_f1_level", a_level, 2);
    block = 1'b1;
    repeat (40) tick();
    check("blk_after_f1_tx", a_tx, 1'b1);
    check("blk_after_f1_state", a_st, ST_IDLE);
    check("blk_after_f1_level", a_level, 2);
    check("blk_after_f1_busy", a_busy, 1'b1);
    repeat (20) tick();
    check("blk_still_held", a_tx, 1'b1);
    block = 1'b0;
    tick();
    check("blk_f2_start", a_tx, 1'b0);
    check("blk_f2_level", a_level, 1);
    drain("blk");
    check("blk_frames", rx_starts.size(), 3);
    if (rx_starts.size() == 3)
      check("blk_f23_gap", rx_starts[2] - rx_starts[1], FRAME_A);

    // reset during a data bit of frame 2
    write_a(8'hA1, 1'b1);
    write_a(8'hA2, 1'b1);
    write_a(8'hA3, 1'b1);
    repeat (48) tick();
    check("rst_mid_state", a_st, ST_DATA);
    check("rst_mid_level", a_level, 1);
    check("rst_mid_pending", exp_q.size(), 2);
    rx_en = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_tx", a_tx, 1'b1);
    check("rst_mid_level0", a_level, 0);
    check("rst_mid_busy", a_busy, 1'b0);
    check("rst_mid_full", a_full, 1'b0);
    for (int c = 0; c < 90; c++) begin
      tick();
      check("rst_no_frames", a_tx, 1'b1);
    end
    exp_q.delete();
    rx_en = 1'b1;

    // random words and gaps
    for (int r = 0; r < 14; r++) begin
      int n;
      bit use_blk;
      logic [7:0] w;
      use_blk = 1'($urandom_range(0, 1));
      if (use_blk) begin
        n = $urandom_range(1, 6);
        block = 1'b1;
        for (int i = 0; i < n; i++) begin
          w = 8'($urandom_range(0, 255));
          write_a(w, i < 4);
          check("rnd_ovf_blk", a_ovf, i >= 4);
        end
        tick();
        check("rnd_level", a_level, (n < 4) ? n : 4);
        check("rnd_ovf_quiet", a_ovf, 1'b0);
        block = 1'b0;
      end else begin
        n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
          w = 8'($urandom_range(0, 255));
          write_a(w, 1'b1);
          check("rnd_ovf_free", a_ovf, 1'b0);
          repeat ($urandom_range(0, 30)) tick();
        end
      end
      drain("rnd");
      repeat ($urandom_range(0, 10)) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/serial_tx_buf.md
# serial_tx_buf

Buffered, parametrised UART-style serial transmitter: accepts bytes (or words of DATA_BITS) on a single-cycle strobe into an internal FIFO and serialises them LSB-first with configurable parity and stop bits at CLK_PER_BIT clocks per bit. It is the next generation of the single-frame `serial_tx`. It sits between fabric logic and a board TX pin (for example, the AVR/USB bridge or an external header). Producers can burst several words without waiting on `busy`.

## Interface
- CLK_PER_BIT, 434, clocks per serial bit; ≥ 2 (434 gives 115200 baud at 50 MHz)
- DATA_BITS, 8, payload bits per frame; 5..9
- PARITY, 0, 0 = none, 1 = odd, 2 = even
- STOP_BITS, 1, 1 or 2
- FIFO_DEPTH, 16, words buffered; power of two, ≥ 2

- clk  in  1  system clock; the single clock domain
- rst  in  1  synchronous reset, active-high
- block  in  1  when high, no new frame starts; a frame in progress completes
- new_data  in  1  write strobe; `data` is enqueued on this cycle if `full`=0
- data  in  DATA_BITS  word to transmit
- full  out  1  FIFO holds FIFO_DEPTH words
- overflow  out  1  one-cycle pulse when `new_data`=1 while `full`=1; the word is dropped
- level  out  $clog2(FIFO_DEPTH)+1  words currently queued, excluding the frame on the wire
- busy  out  1  high while FIFO non-empty or a frame is in progress
- tx  out  1  serial line; idles high

## Operation
- Reset values: tx=1, busy=0, full=0, overflow=0, level=0.
  - The FIFO is emptied and the FSM goes to IDLE.
  - Reset mid-frame aborts the frame; tx is 1 after the reset edge.
- FIFO write: new_data && !full. A pop in the same cycle does not make room; `full` is evaluated before the pop.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO non-empty && !block, pop the head into the shift register and go to START.
  - START: tx=0 for CLK_PER_BIT cycles, then go to DATA.
  - DATA: tx = shift[0]. Shift right every CLK_PER_BIT cycles. After DATA_BITS bits, go to PARITY if PARITY≠0, otherwise STOP.
  - PARITY: tx = ^word for even, ~^word for odd. Parity is computed at pop time over DATA_BITS bits. Hold for CLK_PER_BIT cycles, then go to STOP.
  - STOP: tx=1 for STOP_BITS×CLK_PER_BIT cycles. On the last cycle, if FIFO non-empty && !block, pop and go to START directly (no idle gap). Otherwise go to IDLE.
- Bit timer: counts 0..CLK_PER_BIT-1 with width $clog2(CLK_PER_BIT) and wraps to 0 at each bit boundary. The bit counter has width $clog2(DATA_BITS+1).
- `block` is sampled only at frame-start decisions. Asserting it mid-frame has no effect on the current frame.
- busy = (state≠IDLE) || level≠0.

## Timing
- Latency: new_data sampled at edge k into an empty FIFO with the FSM in IDLE and block=0. The FIFO is written at edge k, the pop happens at edge k+1, and tx=0 from edge k+1.
- Frame length is exactly (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_PER_BIT cycles.
- Back-to-back frames have zero extra idle cycles.
- `full` and `level` update on the edge after a write or pop. Simultaneous write and pop leaves `level` unchanged.
- `overflow` is registered: it is high for the one cycle after the dropped strobe.
- All outputs are registered. `tx` comes directly from a flop, so it is glitch-free.

## Structure
- Shared package `serial_pkg`:
  - parity encodings PAR_NONE/PAR_ODD/PAR_EVEN
  - FSM state encodings
  - baud helper constant CLK_PER_BIT_115200_50M = 434
- Sub-module `fifo_sync`:
  - parameters WIDTH, DEPTH
  - ports clk, rst, wr, din, rd, dout, full, empty, level
  - first-word-fall-through
  - reusable by the future receive path
- The top of serial_tx_buf contains the FSM, the timers and the parity logic only.

## Test plan
- Use CLK_PER_BIT=4 and defaults otherwise. Write 0x61 once. Required: tx low from edge k+1 for 4 cycles, then bits 1,0,0,0,0,1,1,0 at 4 cycles each, then 4 cycles high; busy drops after the stop bit; total 40 cycles.
- Use PARITY=2, STOP_BITS=2 and write 0x07. Required: a parity bit of 1 after the data bits, 8 stop cycles, frame length 48 cycles. With PARITY=1 the parity bit is 0.
- Use FIFO_DEPTH=4 and write 5 words on consecutive cycles while tx is idle. Required: the 5th word is dropped, overflow pulses once, and 4 frames are sent back-to-back with no idle cycle between stop and start.
- Hold block=1 and write 3 words. Required: tx stays 1, level=3, busy=1. Release block; then raise it during frame 1. Required: frame 1 completes and frames 2 and 3 are held until block falls.
- Assert rst during a DATA bit of frame 2. Required: tx=1, level=0, busy=0 on the next cycle, and no further frames are sent.
- Run random words and gaps against a behavioural UART receiver model. Required: every accepted word is received in order, and dropped words match the overflow pulses.
